// File: rtl/key_ctrl_if.sv
// Key controller bus: raw push-button inputs and the counter-stage control outputs.
interface key_ctrl_if;
   logic key_run;
   logic key_clr;
   logic en;
   logic clr;
   logic busy;

   modport master (
      output key_run,
      output key_clr,
      input  en,
      input  clr,
      input  busy
   );

   modport slave (
      input  key_run,
      input  key_clr,
      output en,
      output clr,
      output busy
   );
endinterface

// File: rtl/key_ctrl.sv
// Front-panel key controller: synchronises and debounces the run and clear keys, then
// turns qualified presses into the counter's enable level and a one-cycle clear pulse.
module key_ctrl #(
   parameter int unsigned DEBOUNCE = 20,
   parameter int unsigned CW       = 8
) (
   input logic       clk1k,
   input logic       rst,
   key_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

   localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE - 1);

   // Index 0 is the run key, index 1 the clear key.
   logic [1:0]    r_sync1;
   logic [1:0]    r_sync2;
   state_e        r_state [2];
   logic [CW-1:0] r_cnt   [2];
   logic          r_en;
   logic          r_clr;

   logic [1:0]    w_key;
   logic [1:0]    w_press;
   logic [1:0]    w_wait;

   assign w_key = {bus.key_clr, bus.key_run};

   // Press fires on the edge that moves PRESS_WAIT to PRESSED, so en/clr land on that edge.
   always_comb begin
      w_press = '0;
      w_wait  = '0;
      for (int i = 0; i < 2; i++) begin
         w_press[i] = (r_state[i] == StPressWait) && r_sync2[i] && (r_cnt[i] == CntLast);
         w_wait[i]  = (r_state[i] == StPressWait) || (r_state[i] == StReleaseWait);
      end
   end

   always_ff @(posedge clk1k) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         for (int i = 0; i < 2; i++) begin
            r_state[i] <= StIdle;
            r_cnt[i]   <= '0;
         end
         r_en  <= 1'b0;
         r_clr <= 1'b0;
      end else begin
         r_sync1 <= w_key;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            unique case (r_state[i])
               StIdle: begin
                  if (r_sync2[i]) begin
                     r_cnt[i]   <= '0;
                     r_state[i] <= StPressWait;
                  end
               end
               StPressWait: begin
                  if (!r_sync2[i]) begin
                     r_state[i] <= StIdle;
                  end else if (r_cnt[i] == CntLast) begin
                     r_state[i] <= StPressed;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + CW'(1);
                  end
               end
               StPressed: begin
                  if (!r_sync2[i]) begin
                     r_cnt[i]   <= '0;
                     r_state[i] <= StReleaseWait;
                  end
               end
               StReleaseWait: begin
                  if (r_sync2[i]) begin
                     r_state[i] <= StPressed;
                  end else if (r_cnt[i] == CntLast) begin
                     r_state[i] <= StIdle;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + CW'(1);
                  end
               end
               default: r_state[i] <= StIdle;
            endcase
         end
         // Clear outranks a simultaneous run toggle.
         r_clr <= w_press[1];
         if (w_press[1]) begin
            r_en <= 1'b0;
         end else if (w_press[0]) begin
            r_en <= ~r_en;
         end
      end
   end

   assign bus.en   = r_en;
   assign bus.clr  = r_clr;
   assign bus.busy = |w_wait;

endmodule

// File: tb/tb_key_ctrl.sv
// Bench for key_ctrl: directed scenarios plus random key traffic against a streak-count model.
module tb_key_ctrl;

   localparam int D = 20;

   logic clk1k = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   key_ctrl_if kif ();

   key_ctrl #(
      .DEBOUNCE(D),
      .CW      (8)
   ) dut (
      .clk1k(clk1k),
      .rst  (rst),
      .bus  (kif)
   );

   always #5 clk1k = ~clk1k;

   // Model: keys reach the debouncer two edges late; the accepted level flips once the
   // seen level has disagreed with it on D+1 consecutive edges.
   logic [1:0] m_s1, m_s2, m_acc;
   int         m_streak [2];
   logic       m_en, m_clr, m_busy;

   task automatic tick();
      logic [1:0] ev;
      @(posedge clk1k);
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_acc = '0;
         m_streak[0] = 0; m_streak[1] = 0;
         m_en = 1'b0; m_clr = 1'b0;
      end else begin
         ev = '0;
         for (int k = 0; k < 2; k++) begin
            if (m_s2[k] != m_acc[k]) begin
               m_streak[k]++;
               if (m_streak[k] == D + 1) begin
                  m_acc[k]    = m_s2[k];
                  m_streak[k] = 0;
                  ev[k]       = m_acc[k];
               end
            end else begin
               m_streak[k] = 0;
            end
         end
         m_s2  = m_s1;
         m_s1  = {kif.key_clr, kif.key_run};
         m_clr = ev[1];
         if (ev[1]) m_en = 1'b0;
         else if (ev[0]) m_en = ~m_en;
      end
      m_busy = (m_streak[0] != 0) || (m_streak[1] != 0);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; kif.key_run = 1'b0; kif.key_clr = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({kif.en, kif.clr, kif.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got en/clr/busy=%b%b%b want 000",
                     c, kif.en, kif.clr, kif.busy);
         end
      end
      rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         checks++;
         if ({kif.en, kif.clr, kif.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got en/clr/busy=%b%b%b want 000",
                     c, kif.en, kif.clr, kif.busy);
         end
      end
   endtask

   task automatic test_clean_press();
      int lat;
      for (int p = 0; p < 2; p++) begin
         logic want;
         want = ~m_en;
         kif.key_run = 1'b1;
         lat = -1;
         for (int c = 0; c < 200; c++) begin
            tick();
            if (lat < 0 && kif.en === want) lat = c;
            checks++;
            if ({kif.en, kif.clr, kif.busy} !== {m_en, m_clr, m_busy}) begin
               errors++;
               $display("FAIL press_model p=%0d cyc=%0d got %b%b%b want %b%b%b", p, c,
                        kif.en, kif.clr, kif.busy, m_en, m_clr, m_busy);
            end
         end
         checks++;
         if (lat != 22) begin
            errors++;
            $display("FAIL press_latency p=%0d got %0d want 22", p, lat);
         end
         checks++;
         if (kif.en !== want) begin
            errors++;
            $display("FAIL press_hold p=%0d got en=%b want %b", p, kif.en, want);
         end
         kif.key_run = 1'b0;
         for (int c = 0; c < 50; c++) begin
            tick();
            checks++;
            if ({kif.en, kif.clr, kif.busy} !== {m_en, m_clr, m_busy}) begin
               errors++;
               $display("FAIL release_model p=%0d cyc=%0d got %b%b%b want %b%b%b", p, c,
                        kif.en, kif.clr, kif.busy, m_en, m_clr, m_busy);
            end
         end
      end
   endtask

   task automatic test_bounce();
      logic e0;
      logic saw_busy;
      int   plen [3] = '{0, D - 1, D + 1};
      e0 = m_en;
      saw_busy = 1'b0;
      for (int ph = 0; ph < 3; ph++) begin
         for (int c = 0; c < 100; c++) begin
            if (ph == 0) kif.key_run = (c < 60) && ((c / 5) % 2 == 0);
            else kif.key_run = (c < plen[ph]);
            tick();
            if (kif.busy === 1'b1) saw_busy = 1'b1;
            checks++;
            if ({kif.en, kif.clr, kif.busy} !== {m_en, m_clr, m_busy}) begin
               errors++;
               $display("FAIL bounce_model ph=%0d cyc=%0d got %b%b%b want %b%b%b", ph, c,
                        kif.en, kif.clr, kif.busy, m_en, m_clr, m_busy);
            end
         end
         checks++;
         if (kif.en !== ((ph == 2) ? ~e0 : e0)) begin
            errors++;
            $display("FAIL bounce_en ph=%0d got en=%b want %b", ph, kif.en,
                     (ph == 2) ? ~e0 : e0);
         end
      end
      checks++;
      if (!saw_busy) begin
         errors++;
         $display("FAIL bounce_busy got busy never high want pulses");
      end
   endtask

   task automatic test_clear();
      int pulses, pcyc;
      if (!m_en) begin
         kif.key_run = 1'b1;
         repeat (30) tick();
         kif.key_run = 1'b0;
         repeat (30) tick();
      end
      checks++;
      if (kif.en !== 1'b1) begin
         errors++;
         $display("FAIL clear_setup got en=%b want 1", kif.en);
      end
      kif.key_clr = 1'b1;
      pulses = 0; pcyc = -1;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (kif.clr === 1'b1) begin
            pulses++;
            pcyc = c;
            checks++;
            if (kif.en !== 1'b0) begin
               errors++;
               $display("FAIL clear_en_same_edge got en=%b want 0", kif.en);
            end
         end
         checks++;
         if ({kif.en, kif.clr, kif.busy} !== {m_en, m_clr, m_busy}) begin
            errors++;
            $display("FAIL clear_model cyc=%0d got %b%b%b want %b%b%b", c,
                     kif.en, kif.clr, kif.busy, m_en, m_clr, m_busy);
         end
      end
      checks++;
      if (pulses != 1 || pcyc != 22) begin
         errors++;
         $display("FAIL clear_pulse got pulses=%0d at %0d want 1 at 22", pulses, pcyc);
      end
      kif.key_clr = 1'b0;
      repeat (30) tick();
   endtask

   task automatic test_simultaneous();
      int   pulses;
      logic en_seen;
      kif.key_run = 1'b1;
      kif.key_clr = 1'b1;
      pulses = 0; en_seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (kif.clr === 1'b1) pulses++;
         if (kif.en !== 1'b0) en_seen = 1'b1;
         checks++;
         if ({kif.en, kif.clr, kif.busy} !== {m_en, m_clr, m_busy}) begin
            errors++;
            $display("FAIL simul_model cyc=%0d got %b%b%b want %b%b%b", c,
                     kif.en, kif.clr, kif.busy, m_en, m_clr, m_busy);
         end
      end
      checks++;
      if (pulses != 1 || en_seen) begin
         errors++;
         $display("FAIL simul_result got pulses=%0d en_seen=%b want 1 0", pulses, en_seen);
      end
      kif.key_run = 1'b0;
      kif.key_clr = 1'b0;
      repeat (30) tick();
   endtask

   task automatic test_reset_mid();
      int lat;
      kif.key_run = 1'b1;
      repeat (30) tick();
      kif.key_run = 1'b0;
      repeat (30) tick();
      kif.key_run = 1'b1;
      repeat (12) tick();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({kif.en, kif.clr, kif.busy} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_outputs cyc=%0d got %b%b%b want 000", c,
                     kif.en, kif.clr, kif.busy);
         end
      end
      rst = 1'b0;
      lat = -1;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (lat < 0 && kif.en === 1'b1) lat = c;
         checks++;
         if ({kif.en, kif.clr, kif.busy} !== {m_en, m_clr, m_busy}) begin
            errors++;
            $display("FAIL midrst_model cyc=%0d got %b%b%b want %b%b%b", c,
                     kif.en, kif.clr, kif.busy, m_en, m_clr, m_busy);
         end
      end
      checks++;
      if (lat != 22) begin
         errors++;
         $display("FAIL midrst_latency got %0d want 22", lat);
      end
      kif.key_run = 1'b0;
      repeat (30) tick();
   endtask

   task automatic test_random();
      int c;
      c = 0;
      while (c < 3000) begin
         int len;
         rst         = ($urandom_range(0, 49) == 0);
         kif.key_run = 1'($urandom_range(0, 1));
         kif.key_clr = ($urandom_range(0, 3) == 0);
         len         = rst ? $urandom_range(1, 3) : $urandom_range(1, 40);
         for (int j = 0; j < len; j++) begin
            tick();
            c++;
            checks++;
            if ({kif.en, kif.clr, kif.busy} !== {m_en, m_clr, m_busy}) begin
               errors++;
               $display("FAIL random_model cyc=%0d got %b%b%b want %b%b%b", c,
                        kif.en, kif.clr, kif.busy, m_en, m_clr, m_busy);
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_clear();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
